// File: rtl/pack_line_sched_pkg.sv
// Shared types and default constants for the pixel-packing line scheduler.
package pack_line_sched_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 12;
  localparam int unsigned PACK_DIV_DEF   = 4;
  localparam int unsigned MAX_HRES_DEF   = 540;
  localparam int unsigned DROP_W         = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LINE = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pack_line_sched_edge_det.sv
// Registered copy of a level signal plus a single-edge detector.
// FALLING selects which transition the pulse reports.
module pack_edge_det #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign pulse = FALLING ? (~d & q) : (d & ~q);

endmodule

// File: rtl/pack_line_sched.sv
// Ping-pong line scheduler: assigns input lines to two line-buffer banks,
// hands filled banks to the packer, drops lines when both banks are busy,
// and releases the output timing generator at the first frame line boundary.
module pack_line_sched
  import pack_line_sched_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned PACK_DIV   = PACK_DIV_DEF,
  parameter int unsigned MAX_HRES   = MAX_HRES_DEF
) (
  input  logic                  in_pclk,
  input  logic                  in_rstn,
  input  logic                  in_vs,
  input  logic                  in_hs,
  input  logic                  in_de,
  input  logic                  in_valid,
  input  logic [FIFO_WIDTH-1:0] in_x,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [FIFO_WIDTH-1:0] wr_addr,
  output logic                  rd_start,
  output logic                  rd_bank,
  output logic [FIFO_WIDTH-1:0] rd_words,
  input  logic                  rd_done,
  output logic                  gen_rstn,
  output logic [FIFO_WIDTH-1:0] line_idx,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic                  ovf
);

  localparam int unsigned CW = FIFO_WIDTH + 1;

  logic line_start, line_end, vs_fall, hs_fall;

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [1:0]            full;
  logic [FIFO_WIDTH-1:0] len0, len1;
  logic [FIFO_WIDTH-1:0] pix_cnt;
  logic                  frame_armed;

  logic       accept, drop, commit, trunc, start, clear;
  logic [1:0] set_m, clr_m;
  logic [CW-1:0] words_c;

  pack_edge_det #(.FALLING(1'b0)) u_de_rise (
    .clk(in_pclk), .rst_n(in_rstn), .d(in_de), .pulse(line_start)
  );
  pack_edge_det #(.FALLING(1'b1)) u_de_fall (
    .clk(in_pclk), .rst_n(in_rstn), .d(in_de), .pulse(line_end)
  );
  pack_edge_det #(.FALLING(1'b1)) u_vs_fall (
    .clk(in_pclk), .rst_n(in_rstn), .d(in_vs), .pulse(vs_fall)
  );
  pack_edge_det #(.FALLING(1'b1)) u_hs_fall (
    .clk(in_pclk), .rst_n(in_rstn), .d(in_hs), .pulse(hs_fall)
  );

  assign wr_addr = in_x;

  // Packed word count for the line just finished, rounded up.
  assign words_c = (CW'(pix_cnt) + CW'(PACK_DIV - 1)) / CW'(PACK_DIV);

  // FSM state registers.
  always_ff @(posedge in_pclk) begin
    if (!in_rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write FSM: line acceptance, pixel strobes, bank commit.
  always_comb begin
    w_next = w_state;
    wr_en  = 1'b0;
    accept = 1'b0;
    drop   = 1'b0;
    commit = 1'b0;
    trunc  = 1'b0;
    if (in_rstn) begin
      case (w_state)
        W_IDLE: begin
          if (line_start) begin
            if (!full[wr_bank]) begin
              w_next = W_LINE;
              accept = 1'b1;
              wr_en  = in_valid;
            end else begin
              w_next = W_DROP;
              drop   = 1'b1;
            end
          end
        end
        W_LINE: begin
          if (in_valid && in_de) begin
            if (pix_cnt < FIFO_WIDTH'(MAX_HRES)) wr_en = 1'b1;
            else                                 trunc = 1'b1;
          end
          if (line_end) begin
            w_next = W_IDLE;
            commit = (pix_cnt != '0);
          end
        end
        W_DROP: begin
          if (line_end) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  // Read FSM: announce a full bank, retire it on rd_done.
  always_comb begin
    r_next = r_state;
    start  = 1'b0;
    clear  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          r_next = R_WAIT;
          start  = 1'b1;
        end
      end
      R_WAIT: begin
        if (rd_done) begin
          r_next = R_IDLE;
          clear  = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Bank set/clear masks; opposite banks may change in the same cycle.
  always_comb begin
    set_m = 2'b00;
    clr_m = 2'b00;
    if (commit) set_m[wr_bank] = 1'b1;
    if (clear)  clr_m[rd_bank] = 1'b1;
  end

  // Write-side datapath, bank status and frame bookkeeping.
  always_ff @(posedge in_pclk) begin
    if (!in_rstn) begin
      full        <= 2'b00;
      len0        <= '0;
      len1        <= '0;
      pix_cnt     <= '0;
      wr_bank     <= 1'b0;
      line_idx    <= '0;
      drop_cnt    <= '0;
      ovf         <= 1'b0;
      frame_armed <= 1'b0;
      gen_rstn    <= 1'b0;
    end else begin
      if (accept)     pix_cnt <= FIFO_WIDTH'(wr_en);
      else if (wr_en) pix_cnt <= pix_cnt + FIFO_WIDTH'(1);

      full <= (full | set_m) & ~clr_m;

      if (commit) begin
        if (wr_bank) len1 <= FIFO_WIDTH'(words_c);
        else         len0 <= FIFO_WIDTH'(words_c);
        wr_bank <= ~wr_bank;
      end

      if (vs_fall)     line_idx <= '0;
      else if (commit) line_idx <= line_idx + FIFO_WIDTH'(1);

      if (drop && drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
      if (drop || trunc) ovf <= 1'b1;

      if (vs_fall)                 frame_armed <= 1'b1;
      if (hs_fall && frame_armed)  gen_rstn    <= 1'b1;
    end
  end

  // Read-side registered outputs.
  always_ff @(posedge in_pclk) begin
    if (!in_rstn) begin
      rd_start <= 1'b0;
      rd_words <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_start <= start;
      if (start) rd_words <= rd_bank ? len1 : len0;
      if (clear) rd_bank  <= ~rd_bank;
    end
  end

endmodule
